autorange_ctrl: RTL and testbench
=================================

# autorange_ctrl

Automatic gain-ranging controller for the ECG front-end relay ladder. It watches ADC samples, tracks the peak deviation from mid-scale over a fixed window, and issues single-cycle step requests to the gain-step counter. The counter has a range of 0..13, resets to 5, and latches when it reaches 0 or 13. The block sits between the ADC capture path and the relay-logic counter, and enforces a settle hold-off after every step so that relay transients are never measured.

## Interface
- SAMPLE_W, 12, ADC sample width; samples are unsigned offset-binary with mid-scale 2^(SAMPLE_W-1)
- WINDOW, 256, valid samples per measurement window (≥2)
- HI_THRESH, 1900, peak magnitude at or above which gain is reduced
- LO_THRESH, 400, peak magnitude below which gain is increased; LO_THRESH < HI_THRESH required
- SETTLE_SAMPLES, 64, valid samples discarded after each step (≥1)

Ports:
- clock  in  1  system clock; all logic rising-edge
- reset  in  1  synchronous, active-high
- sample_valid  in  1  qualifies sample for one cycle
- sample  in  SAMPLE_W  ADC code
- count_in  in  4  current gain-step count from the counter
- toHigh  out  1  signal too large: request count decrement (lower gain)
- toLow  out  1  signal too small: request count increment (higher gain)
- enable  out  1  step strobe to the counter, coincident with toHigh/toLow
- settling  out  1  high while in the SETTLE state
- peak_out  out  SAMPLE_W-1  peak magnitude of the last completed window

## Operation
- Magnitude: mag = sample ≥ mid ? sample − mid : (mid−1) − sample. The range is 0..mid−1 and the width is SAMPLE_W−1, so no overflow is possible.
- FSM states are MEASURE, DECIDE, STEP and SETTLE.
- **MEASURE**
  - On each sample_valid: peak ← max(peak, mag) and win_cnt increments.
  - The sample_valid that brings win_cnt to WINDOW → DECIDE.
- **DECIDE** (1 cycle)
  - Always: peak_out ← final peak.
  - If peak ≥ HI_THRESH and count_in ≥ 2, select a down step.
  - Else if peak < LO_THRESH and count_in ≤ 11, select an up step.
  - Otherwise select none.
  - Guards keep the counter inside 1..12 so it never reaches its lock-up ends.
  - Step selected → STEP; none → MEASURE, with peak and win_cnt cleared.
- **STEP** (1 cycle)
  - enable = 1 and exactly one of toHigh/toLow = 1.
  - → SETTLE, with peak and win_cnt cleared.
- **SETTLE**
  - settling = 1; valid samples are counted but not measured.
  - After SETTLE_SAMPLES valid samples → MEASURE.
- sample_valid during DECIDE or STEP is discarded and not counted.
- toHigh and toLow are never asserted together, and never asserted without enable.
- count_in is sampled only in DECIDE.

## Timing
- Reset values:
  - state = MEASURE; peak = 0; win_cnt = 0; settle count = 0.
  - toHigh = toLow = enable = settling = 0; peak_out = 0.
- All outputs are registered.
- Step latency: the last window sample is accepted at edge N, DECIDE occupies cycle N+1, and enable/toHigh/toLow are high for exactly cycle N+2.
- settling rises at cycle N+3.
- Minimum spacing between enable pulses is WINDOW + SETTLE_SAMPLES valid samples plus 2 cycles.
- Reset asserted in any state aborts immediately. No enable pulse is issued on the reset cycle or after it; any pending step is lost.
- sample_valid asserted back-to-back every cycle is supported.

## Configuration
- **AUTORANGE_FAST_CLIP_EN** defined:
  - In MEASURE, a valid sample equal to 0 or 2^SAMPLE_W−1 (hard clip) aborts the window and goes directly to DECIDE.
  - DECIDE forces the down-step decision, still subject to the count_in ≥ 2 guard.
  - peak_out ← mid−1.
  - Worst-case reaction to saturation is 3 cycles.
- Undefined: clip codes are ordinary samples, and the decision is made only at window end.

## Test plan
- **Reset state:** Reset with sample_valid toggling → all outputs 0, peak_out = 0, and no enable for 10 cycles after reset falls with no samples.
- **Overrange:**
  - Stimulus: 256 valid samples with the value 4000 (mag 1952) and count_in = 5.
  - Response: one enable + toHigh pulse exactly 2 cycles after the 256th sample; peak_out = 1952; settling high for the next 64 valid samples.
- **Underrange:**
  - Stimulus: 256 samples alternating 2100/1995 (peaks 52), count_in = 5.
  - Response: enable + toLow pulse; peak_out = 52.
- **In-band and limit guards:**
  - 256 samples with peak 1000 → no pulse; MEASURE restarts with peak cleared.
  - Overrange window with count_in = 1 → no pulse.
  - Underrange window with count_in = 12 → no pulse.
- **Reset mid-operation:** Reset asserted during the DECIDE cycle of an overrange window → no enable pulse, state MEASURE, win_cnt = 0.
- **Fast clip:**
  - With AUTORANGE_FAST_CLIP_EN, a sample of 4095 as the 10th sample → toHigh pulse 2 cycles later, peak_out = 2047.
  - Without the macro → no pulse until the 256th sample.

Source files
------------

// File: rtl/autorange_ctrl.sv
// Auto gain-ranging controller: windowed peak-deviation tracking with guarded step requests.
// Optional AUTORANGE_FAST_CLIP_EN: a hard-clip sample ends the window early and forces a down step.
module autorange_ctrl #(
  parameter int SAMPLE_W       = 12,
  parameter int WINDOW         = 256,
  parameter int HI_THRESH      = 1900,
  parameter int LO_THRESH      = 400,
  parameter int SETTLE_SAMPLES = 64
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic [3:0]          count_in,
  output logic                toHigh,
  output logic                toLow,
  output logic                enable,
  output logic                settling,
  output logic [SAMPLE_W-2:0] peak_out
);
  localparam int MW  = SAMPLE_W - 1;
  localparam int WCW = $clog2(WINDOW + 1);
  localparam int SCW = $clog2(SETTLE_SAMPLES + 1);
  localparam logic [MW-1:0]  MAG_MAX  = {MW{1'b1}};
  localparam logic [MW-1:0]  HI       = MW'(HI_THRESH);
  localparam logic [MW-1:0]  LO       = MW'(LO_THRESH);
  localparam logic [WCW-1:0] WIN_LAST = WCW'(WINDOW - 1);
  localparam logic [SCW-1:0] SET_LAST = SCW'(SETTLE_SAMPLES - 1);

`ifdef AUTORANGE_FAST_CLIP_EN
  localparam bit FAST_CLIP = 1'b1;
`else
  localparam bit FAST_CLIP = 1'b0;
`endif

  typedef enum logic [1:0] {MEASURE, DECIDE, STEP, SETTLE} state_t;

  state_t         state_q, state_d;
  logic [MW-1:0]  peak_q, peak_d, peak_out_q, peak_out_d;
  logic [WCW-1:0] win_q, win_d;
  logic [SCW-1:0] set_q, set_d;
  logic           clip_q, clip_d;
  logic           dn_q, dn_d;
  logic           en_q, hi_q, lo_q, settling_q;
  logic [MW-1:0]  mag;
  logic           clip_hit;

  // Offset-binary fold: upper half is sample-mid, lower half is (mid-1)-sample.
  always_comb begin
    mag = sample[SAMPLE_W-1] ? sample[MW-1:0] : ~sample[MW-1:0];
  end

  assign clip_hit = FAST_CLIP && ((sample == '0) || (sample == '1));

  always_comb begin
    state_d    = state_q;
    peak_d     = peak_q;
    win_d      = win_q;
    set_d      = set_q;
    clip_d     = clip_q;
    dn_d       = dn_q;
    peak_out_d = peak_out_q;
    case (state_q)
      MEASURE: begin
        if (sample_valid) begin
          if (mag > peak_q) peak_d = mag;
          win_d = win_q + 1'b1;
          if (win_q == WIN_LAST) state_d = DECIDE;
          if (clip_hit) begin
            clip_d  = 1'b1;
            state_d = DECIDE;
          end
        end
      end
      DECIDE: begin
        peak_out_d = clip_q ? MAG_MAX : peak_q;
        // Guards keep the counter within 1..12 so it never hits its latching ends.
        if ((clip_q || peak_q >= HI) && count_in >= 4'd2) begin
          dn_d    = 1'b1;
          state_d = STEP;
        end else if (!clip_q && peak_q < LO && count_in <= 4'd11) begin
          dn_d    = 1'b0;
          state_d = STEP;
        end else begin
          state_d = MEASURE;
          peak_d  = '0;
          win_d   = '0;
          clip_d  = 1'b0;
        end
      end
      STEP: begin
        state_d = SETTLE;
        peak_d  = '0;
        win_d   = '0;
        clip_d  = 1'b0;
        set_d   = '0;
      end
      SETTLE: begin
        if (sample_valid) begin
          set_d = set_q + 1'b1;
          if (set_q == SET_LAST) begin
            state_d = MEASURE;
            set_d   = '0;
          end
        end
      end
      default: state_d = MEASURE;
    endcase
  end

  // Outputs are registered from the next state so they line up with STEP/SETTLE exactly.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= MEASURE;
      peak_q     <= '0;
      win_q      <= '0;
      set_q      <= '0;
      clip_q     <= 1'b0;
      dn_q       <= 1'b0;
      peak_out_q <= '0;
      en_q       <= 1'b0;
      hi_q       <= 1'b0;
      lo_q       <= 1'b0;
      settling_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      peak_q     <= peak_d;
      win_q      <= win_d;
      set_q      <= set_d;
      clip_q     <= clip_d;
      dn_q       <= dn_d;
      peak_out_q <= peak_out_d;
      en_q       <= (state_d == STEP);
      hi_q       <= (state_d == STEP) && dn_d;
      lo_q       <= (state_d == STEP) && !dn_d;
      settling_q <= (state_d == SETTLE);
    end
  end

  assign enable   = en_q;
  assign toHigh   = hi_q;
  assign toLow    = lo_q;
  assign settling = settling_q;
  assign peak_out = peak_out_q;
endmodule

// File: tb/tb_autorange_ctrl.sv
// Directed bench for autorange_ctrl: reset, over/under-range steps, guards, reset abort, fast clip.
module tb_autorange_ctrl;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        sample_valid = 1'b0;
  logic [11:0] sample = 12'd2048;
  logic [3:0]  count_in = 4'd5;
  logic        toHigh, toLow, enable, settling;
  logic [10:0] peak_out;
  int          checks = 0;
  int          passed = 0;
  int          en_cnt = 0;

  autorange_ctrl dut (
    .clock(clock), .reset(reset), .sample_valid(sample_valid), .sample(sample),
    .count_in(count_in), .toHigh(toHigh), .toLow(toLow), .enable(enable),
    .settling(settling), .peak_out(peak_out)
  );

  always #5 clock = ~clock;
  always @(posedge clock) if (enable) en_cnt <= en_cnt + 1;

  // Drives n back-to-back valid samples alternating a/b; returns 1ns after the last accepting edge.
  task automatic drive(input logic [11:0] a, input logic [11:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      sample_valid = 1'b1;
      sample = (i % 2 == 0) ? a : b;
    end
    @(posedge clock); #1;
    sample_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1;
    end
  endtask

  // Walks a SETTLE phase: high for 63 samples, low right after the 64th.
  task automatic run_settle(input string nm);
    drive(12'd2048, 12'd2048, 63);
    checks++; if (settling !== 1'b1) $display("FAIL %s_settle_hold: got %b want 1", nm, settling); else passed++;
    drive(12'd2048, 12'd2048, 1);
    checks++; if (settling !== 1'b0) $display("FAIL %s_settle_end: got %b want 0", nm, settling); else passed++;
  endtask

  // Checks an expected step pulse, called right after the last window sample edge.
  task automatic expect_pulse(input string nm, input logic down, input logic [10:0] pk);
    int e0;
    e0 = en_cnt;
    checks++; if (enable !== 1'b0) $display("FAIL %s_decide_en: got %b want 0", nm, enable); else passed++;
    idle(1);
    checks++; if ({enable, toHigh, toLow} !== {1'b1, down, ~down})
      $display("FAIL %s_pulse: got en/hi/lo=%b%b%b want 1%b%b", nm, enable, toHigh, toLow, down, ~down); else passed++;
    checks++; if (peak_out !== pk) $display("FAIL %s_peak: got %0d want %0d", nm, peak_out, pk); else passed++;
    idle(1);
    checks++; if ({enable, settling} !== 2'b01) $display("FAIL %s_post: got en/settling=%b%b want 01", nm, enable, settling); else passed++;
    checks++; if (en_cnt - e0 !== 1) $display("FAIL %s_pulse_count: got %0d want 1", nm, en_cnt - e0); else passed++;
  endtask

  task automatic expect_none(input string nm, input logic [10:0] pk);
    int e0;
    e0 = en_cnt;
    idle(4);
    checks++; if (en_cnt - e0 !== 0) $display("FAIL %s_no_pulse: got %0d pulses want 0", nm, en_cnt - e0); else passed++;
    checks++; if (settling !== 1'b0) $display("FAIL %s_settling: got %b want 0", nm, settling); else passed++;
    checks++; if (peak_out !== pk) $display("FAIL %s_peak: got %0d want %0d", nm, peak_out, pk); else passed++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    sample = 12'd4000;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock); sample_valid = ~sample_valid;
      @(posedge clock); #1;
      checks++; if ({enable, toHigh, toLow, settling, peak_out} !== 15'd0)
        $display("FAIL reset_outputs: got en/hi/lo/set=%b%b%b%b peak=%0d want all 0", enable, toHigh, toLow, settling, peak_out); else passed++;
    end
    @(negedge clock); sample_valid = 1'b0; reset = 1'b0;
    en_cnt = 0;
    idle(10);
    checks++; if (en_cnt !== 0) $display("FAIL reset_idle_enable: got %0d pulses want 0", en_cnt); else passed++;
  endtask

  task automatic test_overrange();
    count_in = 4'd5;
    drive(12'd4000, 12'd4000, 256);
    expect_pulse("ovr", 1'b1, 11'd1952);
    run_settle("ovr");
  endtask

  task automatic test_underrange();
    count_in = 4'd5;
    drive(12'd2100, 12'd1995, 256);
    expect_pulse("und", 1'b0, 11'd52);
    run_settle("und");
  endtask

  task automatic test_guards();
    count_in = 4'd5;
    drive(12'd3048, 12'd2048, 256);
    expect_none("inband", 11'd1000);
    // Follow-on quiet window proves the 1000 peak was cleared.
    drive(12'd2100, 12'd1995, 256);
    expect_pulse("inband_restart", 1'b0, 11'd52);
    run_settle("inband_restart");
    count_in = 4'd1;
    drive(12'd4000, 12'd4000, 256);
    expect_none("guard_lo", 11'd1952);
    count_in = 4'd12;
    drive(12'd2100, 12'd1995, 256);
    expect_none("guard_hi", 11'd52);
    count_in = 4'd5;
  endtask

  task automatic test_reset_mid();
    int e0;
    e0 = en_cnt;
    drive(12'd4000, 12'd4000, 256);
    reset = 1'b1;
    idle(1);
    checks++; if ({enable, toHigh, toLow} !== 3'b000) $display("FAIL rst_mid_pulse: got en/hi/lo=%b%b%b want 000", enable, toHigh, toLow); else passed++;
    @(negedge clock); reset = 1'b0;
    idle(5);
    checks++; if (en_cnt - e0 !== 0) $display("FAIL rst_mid_lost_step: got %0d pulses want 0", en_cnt - e0); else passed++;
    checks++; if (peak_out !== 11'd0) $display("FAIL rst_mid_peak: got %0d want 0", peak_out); else passed++;
    // 255 samples must not close a window if win_cnt restarted from 0.
    drive(12'd4000, 12'd4000, 255);
    idle(3);
    checks++; if (en_cnt - e0 !== 0) $display("FAIL rst_mid_wincnt: got %0d pulses want 0", en_cnt - e0); else passed++;
    drive(12'd4000, 12'd4000, 1);
    expect_pulse("rst_mid_full", 1'b1, 11'd1952);
    run_settle("rst_mid_full");
  endtask

  task automatic test_fast_clip();
    count_in = 4'd5;
    drive(12'd2048, 12'd2048, 9);
    drive(12'd4095, 12'd4095, 1);
`ifdef AUTORANGE_FAST_CLIP_EN
    expect_pulse("clip", 1'b1, 11'd2047);
    run_settle("clip");
`else
    begin
      int e0;
      e0 = en_cnt;
      idle(3);
      checks++; if (en_cnt - e0 !== 0) $display("FAIL clip_off_early: got %0d pulses want 0", en_cnt - e0); else passed++;
      drive(12'd2048, 12'd2048, 246);
      expect_pulse("clip_off_window", 1'b1, 11'd2047);
      run_settle("clip_off");
    end
`endif
  endtask

  initial begin
    test_reset();
    test_overrange();
    test_underrange();
    test_guards();
    test_reset_mid();
    test_fast_clip();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1);
  end
endmodule
